// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: frames LEN, 4*N big-endian data bytes and an
// XOR checksum; writes packed words to instruction memory and releases cpu_hold on success.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

  state_t              state;
  logic [ADDR_WIDTH:0] n_words;
  logic [1:0]          byte_cnt;
  logic [7:0]          csum;
  logic                transfer;

  // Both strobes decode straight from the state register, so imem_we falls the
  // instant reset_n asserts and a half-built word can never be written.
  assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign imem_we    = (state == S_WRITE);
  assign transfer   = byte_valid && byte_ready;

  // NOTE: every register here is updated with <= so all next-state terms read the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      n_words      <= '0;
      byte_cnt     <= '0;
      csum         <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            csum         <= '0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            state        <= S_LEN;
          end
        end

        S_LEN: begin
          if (transfer) begin
            n_words   <= (byte_in == 8'd0) ? DEPTH_W : (ADDR_WIDTH + 1)'(byte_in);
            imem_addr <= '0;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (transfer) begin
            imem_wdata <= {imem_wdata[23:0], byte_in};
            csum       <= csum ^ byte_in;
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= S_WRITE;
          end
        end

        S_WRITE: begin
          words_loaded <= words_loaded + ONE_W;
          // The last word goes to CSUM without bumping the address, so a full
          // DEPTH image never wraps back to address 0.
          if (words_loaded + ONE_W == n_words) begin
            state <= S_CSUM;
          end else begin
            imem_addr <= imem_addr + ONE_A;
            state     <= S_DATA;
          end
        end

        S_CSUM: begin
          if (transfer) begin
            busy <= 1'b0;
            if (byte_in == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame vectors with random data checked against a
// queue-based model of the expected memory writes and final status flags.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic       prev_we = 1'b0;
  logic [7:0] frame_data[DEPTH*4];

  // Write monitor: records every memory write and checks the WRITE-cycle strobes.
  always @(negedge clock) begin
    if (imem_we) begin
      got_q.push_back('{imem_addr, imem_wdata});
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      check("we_single_pulse", 32'(prev_we), 32'd0);
    end
    prev_we = imem_we;
  end

  // Entered and left on a negedge; waits a bounded time for byte_ready.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_in    = b;
    waited     = 0;
    while (!byte_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!byte_ready) begin
      errors++;
      $display("FAIL byte_ready_timeout: got 0x0, expected 0x1");
    end else begin
      @(negedge clock);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] len_byte;
    bit         corrupt;
    int         gap;
    bit         reuse;
    bit         start_mid;
    bit         exp_done;
    bit         exp_error;
    int         exp_words;
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    int         n;
    logic [7:0] x;
    n = (v.len_byte == 8'd0) ? DEPTH : int'(v.len_byte);
    x = 8'd0;
    if (!v.reuse)
      for (int i = 0; i < 4 * n; i++) frame_data[i] = 8'($urandom);
    exp_q.delete();
    got_q.delete();
    for (int w = 0; w < n; w++)
      exp_q.push_back('{AW'(w), {frame_data[4*w], frame_data[4*w+1],
                                 frame_data[4*w+2], frame_data[4*w+3]}});
    for (int i = 0; i < 4 * n; i++) x = x ^ frame_data[i];

    pulse_start();
    check($sformatf("v%0d_start_busy", idx), 32'(busy), 32'd1);
    check($sformatf("v%0d_start_hold", idx), 32'(cpu_hold), 32'd1);
    check($sformatf("v%0d_start_flags", idx), {30'd0, done, error}, 32'd0);
    check($sformatf("v%0d_start_words", idx), 32'(words_loaded), 32'd0);

    send_byte(v.len_byte, $urandom_range(v.gap, 0));
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(frame_data[i], $urandom_range(v.gap, 0));
      if (v.start_mid && i == 1) begin
        pulse_start();
        check($sformatf("v%0d_mid_start_busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d_mid_start_ready", idx), 32'(byte_ready), 32'd1);
      end
    end
    send_byte(v.corrupt ? (x ^ 8'h01) : x, $urandom_range(v.gap, 0));
    @(negedge clock);

    check($sformatf("v%0d_write_count", idx), 32'(got_q.size()), 32'(v.exp_words));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("v%0d_addr%0d", idx, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("v%0d_data%0d", idx, i), got_q[i].data, exp_q[i].data);
    end
    check($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
    check($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_error));
    check($sformatf("v%0d_hold", idx), 32'(cpu_hold), 32'(!v.exp_done));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.exp_words));
    check($sformatf("v%0d_ready_idle", idx), 32'(byte_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_flags"}, {29'd0, busy, done, error}, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'd1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{8'd3, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[2] = '{8'd3, 1'b0, 7, 1'b1, 1'b0, 1'b1, 1'b0, 3};   // same data as [1], with gaps
    vecs[3] = '{8'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 256};
    vecs[4] = '{8'd5, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 5};
    vecs[5] = '{8'd4, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    vecs[6] = '{8'd2, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 2};

    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset");
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    repeat (3) @(negedge clock);
    byte_valid = 1'b0;
    check_reset_outputs("idle_no_start");

    // Known two-word image; its data bytes XOR to 0x00, so 0x01 is a bad checksum.
    {frame_data[0], frame_data[1], frame_data[2], frame_data[3]} = 32'h12345678;
    {frame_data[4], frame_data[5], frame_data[6], frame_data[7]} = 32'h9ABCDEF0;
    run_frame('{8'd2, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2}, 100);
    if (got_q.size() == 2) begin
      check("known_word0", got_q[0].data, 32'h12345678);
      check("known_word1", got_q[1].data, 32'h9ABCDEF0);
    end else begin
      check("known_count", 32'(got_q.size()), 32'd2);
    end
    run_frame('{8'd2, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2}, 101);
    run_frame('{8'd2, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2}, 102);

    // start in DONE clears status and returns to LEN, then a one-word frame completes.
    got_q.delete();
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_ready", 32'(byte_ready), 32'd1);
    check("restart_words", 32'(words_loaded), 32'd0);
    send_byte(8'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h00, 0);
    @(negedge clock);
    check("restart_writes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("restart_data", got_q[0].data, 32'hAABBCCDD);
    check("restart_final_done", 32'(done), 32'd1);

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Reset in the middle of word assembly: nothing written, outputs back to reset.
    got_q.delete();
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_data");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_data_nowrite", 32'(got_q.size()), 32'd0);

    // Reset during the WRITE cycle: imem_we must fall without waiting for a clock.
    pulse_start();
    send_byte(8'd1, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    check("write_we_high", 32'(imem_we), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_write");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
